// File: rtl/arcade_input_cond_if.sv
// Joystick bus between the hps_io joystick decode and the arcade core inputs.
// The master drives the raw bits; the slave returns the conditioned bits and coin status.
interface arcade_input_cond_if;
  logic [7:0] joy_in;
  logic [7:0] joy_out;
  logic       coin_busy;
  logic       coin_pending;
  logic       tick;

  modport master (output joy_in, input joy_out, coin_busy, coin_pending, tick);
  modport slave  (input joy_in, output joy_out, coin_busy, coin_pending, tick);
endinterface

// File: rtl/arcade_input_cond.sv
// Synchronises and debounces raw joystick bits, then shapes the coin bit into
// arcade-timed credit pulses with a lockout gap and a single queued coin.
//
// state | meaning
// IDLE  | no credit in progress, coin output low
// PULSE | credit pulse active, coin output high for COIN_MS ticks
// GAP   | lockout after a pulse, coin output forced low for GAP_MS ticks
module arcade_input_cond #(
  parameter int TICK_DIV = 30000,
  parameter int DEB_MS   = 5,
  parameter int COIN_MS  = 50,
  parameter int GAP_MS   = 50
) (
  input logic                clk_sys,
  input logic                reset_n,
  arcade_input_cond_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  // Comparing against N-1 is the same test as counter+1 == N without widening.
  localparam logic [7:0] DEB_LAST  = 8'(DEB_MS - 1);
  localparam logic [7:0] COIN_LAST = 8'(COIN_MS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_MS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;

  logic [PW-1:0] r_presc;
  logic [7:0]    r_sync1;
  logic [7:0]    r_raw_s;
  logic [7:0]    r_stable;
  logic          r_coin_d;
  logic [7:0]    r_deb [8];
  logic [6:0]    r_joy_lo;
  state_t        r_state;
  logic [7:0]    r_cc;
  logic          r_coin;
  logic          r_busy;
  logic          r_pending;
  logic          w_tick;
  logic          w_coin_rise;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_coin_rise = r_stable[7] & ~r_coin_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_raw_s  <= '0;
      r_stable <= '0;
      r_coin_d <= 1'b0;
      r_joy_lo <= '0;
      for (int i = 0; i < 8; i++) r_deb[i] <= '0;
    end else begin
      r_sync1  <= bus.joy_in;
      r_raw_s  <= r_sync1;
      r_coin_d <= r_stable[7];
      r_joy_lo <= r_stable[6:0];
      for (int i = 0; i < 8; i++) begin
        if (r_raw_s[i] == r_stable[i]) begin
          r_deb[i] <= '0;
        end else if (w_tick) begin
          if (r_deb[i] == DEB_LAST) begin
            r_stable[i] <= r_raw_s[i];
            r_deb[i]    <= '0;
          end else begin
            r_deb[i] <= r_deb[i] + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cc      <= '0;
      r_coin    <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_coin_rise || r_pending) begin
            r_state   <= ST_PULSE;
            r_cc      <= '0;
            r_coin    <= 1'b1;
            r_busy    <= 1'b1;
            r_pending <= w_coin_rise & r_pending;
          end else begin
            r_coin <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (w_coin_rise) r_pending <= 1'b1;
          if (w_tick) begin
            if (r_cc == COIN_LAST) begin
              r_state <= ST_GAP;
              r_cc    <= '0;
              r_coin  <= 1'b0;
            end else begin
              r_cc <= r_cc + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_coin_rise) r_pending <= 1'b1;
          if (w_tick) begin
            if (r_cc == GAP_LAST) begin
              r_cc <= '0;
              // A rise landing on the gap's last tick stays queued so it is never lost.
              if (r_pending) begin
                r_state   <= ST_PULSE;
                r_coin    <= 1'b1;
                r_pending <= w_coin_rise;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cc <= r_cc + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cc      <= '0;
          r_coin    <= 1'b0;
          r_busy    <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign bus.joy_out      = {r_coin, r_joy_lo};
  assign bus.coin_busy    = r_busy;
  assign bus.coin_pending = r_pending;
  assign bus.tick         = w_tick;
endmodule
